// File: rtl/mab_pkg.sv
// Shared types and constants for the memory-address-bus sequencer.
package mab_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SRC = 2'd1,
    ACCESS   = 2'd2,
    DONE     = 2'd3
  } mab_state_t;

  localparam int SRC_PC   = 0;
  localparam int SRC_SOUT = 1;
  localparam int SRC_CALC = 2;
  localparam int SRC_SP   = 3;
  localparam int SRC_MDB  = 4;

  localparam logic [15:0] MAB_RESET_ADDR = 16'hFFFE;

endpackage

// File: rtl/mab_wait_counter.sv
// Wait-state down-counter: load on ACCESS entry, decrement while enabled, saturate at 0.
// Single-cycle load/decrement; no handshake, o_zero is a pure function of the count.
module mab_wait_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/mab_sequencer.sv
// MAB source select + bus-access sequencer; start->mab_valid 1 edge, ->mab_done 2 edges (+waits/mem_ready stall).
// Stalls on src_valid (WAIT_SRC) and mem_ready (ACCESS); MAB_ALIGN_CHECK_EN adds misaligned-word abort.
module mab_sequencer
  import mab_pkg::*;
#(
  parameter int                 ADDR_W      = 16,
  parameter int                 NSRC        = 5,
  parameter int                 SEL_W       = 3,
  parameter int                 WAIT_STATES = 0,
  parameter logic [ADDR_W-1:0]  RESET_ADDR  = ADDR_W'(MAB_RESET_ADDR)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NSRC*ADDR_W-1:0] src_addr,
  input  logic [NSRC-1:0]        src_valid,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   start,
  input  logic                   rw,
  input  logic                   bw,
  input  logic                   mem_ready,
  output logic [ADDR_W-1:0]      mab_addr,
  output logic                   mab_valid,
  output logic                   mab_rw,
  output logic                   mab_bw,
  output logic                   busy,
  output logic                   mab_done,
  output logic                   align_err
);

  mab_state_t        r_state;
  logic [ADDR_W-1:0] r_mab_addr;
  logic              r_mab_valid;
  logic              r_mab_rw;
  logic              r_mab_bw;
  logic              r_busy;
  logic              r_mab_done;
  logic              r_align_err;
  logic [SEL_W-1:0]  r_sel_q;

  logic [ADDR_W-1:0] w_src [NSRC];
  logic [SEL_W-1:0]  w_idle_idx;
  logic [SEL_W-1:0]  w_cur_idx;
  logic              w_cur_bw;
  logic [ADDR_W-1:0] w_raw_addr;
  logic [ADDR_W-1:0] w_bus_addr;
  logic              w_src_ready;
  logic              w_align_fail;
  logic              w_go_access;
  logic              w_cnt_zero;

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    assign w_src[gi] = src_addr[gi*ADDR_W +: ADDR_W];
  end

  // Out-of-range selects fall back to PC.
  assign w_idle_idx = (32'(sel) >= NSRC) ? SEL_W'(SRC_PC) : sel;

  // In IDLE the live request decides; afterwards only the latched copy matters.
  assign w_cur_idx  = (r_state == IDLE) ? w_idle_idx : r_sel_q;
  assign w_cur_bw   = (r_state == IDLE) ? bw : r_mab_bw;
  assign w_raw_addr = w_src[w_cur_idx];
  assign w_bus_addr = w_cur_bw ? w_raw_addr : {w_raw_addr[ADDR_W-1:1], 1'b0};

  assign w_src_ready = (((r_state == IDLE) && start) || (r_state == WAIT_SRC))
                       && src_valid[w_cur_idx];

`ifdef MAB_ALIGN_CHECK_EN
  assign w_align_fail = w_src_ready && !w_cur_bw && w_raw_addr[0];
`else
  assign w_align_fail = 1'b0;
`endif

  assign w_go_access = w_src_ready && !w_align_fail;

  mab_wait_counter u_wait_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_go_access),
    .i_load_val (4'(WAIT_STATES)),
    .i_dec      (r_state == ACCESS),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mab_addr  <= RESET_ADDR;
      r_mab_valid <= 1'b0;
      r_mab_rw    <= 1'b0;
      r_mab_bw    <= 1'b0;
      r_busy      <= 1'b0;
      r_mab_done  <= 1'b0;
      r_align_err <= 1'b0;
      r_sel_q     <= '0;
    end else begin
      r_mab_done  <= 1'b0;
      r_align_err <= 1'b0;
      if ((r_state == IDLE) && start) begin
        r_sel_q  <= w_idle_idx;
        r_mab_rw <= rw;
        r_mab_bw <= bw;
      end
      if (w_go_access) begin
        r_state     <= ACCESS;
        r_mab_addr  <= w_bus_addr;
        r_mab_valid <= 1'b1;
        r_busy      <= 1'b1;
      end else if (w_align_fail) begin
        // Abort without touching the bus: address stays where it was.
        r_state     <= IDLE;
        r_align_err <= 1'b1;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_state    <= WAIT_SRC;
              r_busy     <= 1'b1;
              r_mab_addr <= w_src[SRC_PC];
            end
          end
          WAIT_SRC: begin
            r_mab_addr <= w_src[SRC_PC];
          end
          ACCESS: begin
            if (w_cnt_zero && mem_ready) begin
              r_state     <= DONE;
              r_mab_valid <= 1'b0;
              r_mab_done  <= 1'b1;
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mab_addr  = r_mab_addr;
  assign mab_valid = r_mab_valid;
  assign mab_rw    = r_mab_rw;
  assign mab_bw    = r_mab_bw;
  assign busy      = r_busy;
  assign mab_done  = r_mab_done;
  assign align_err = r_align_err;

endmodule

// File: tb/tb_mab_sequencer.sv
// Bench: three sequencers (WAIT_STATES 0/2/3) on shared random stimulus vs a transaction-level model.
module tb_mab_sequencer;

  localparam int AW = 16;
  localparam int NS = 5;
  localparam int SW = 3;
  localparam int NI = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NS*AW-1:0]  src_addr;
  logic [NS-1:0]     src_valid;
  logic [SW-1:0]     sel;
  logic              start, rw, bw, mem_ready;

  logic [AW-1:0] d_addr [NI];
  logic d_valid [NI];
  logic d_rw    [NI];
  logic d_bw    [NI];
  logic d_busy  [NI];
  logic d_done  [NI];
  logic d_err   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mab_sequencer #(
      .ADDR_W(AW), .NSRC(NS), .SEL_W(SW),
      .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 2 : 3)),
      .RESET_ADDR(16'hFFFE)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .src_addr(src_addr), .src_valid(src_valid),
      .sel(sel), .start(start), .rw(rw), .bw(bw), .mem_ready(mem_ready),
      .mab_addr(d_addr[g]), .mab_valid(d_valid[g]), .mab_rw(d_rw[g]),
      .mab_bw(d_bw[g]), .busy(d_busy[g]), .mab_done(d_done[g]),
      .align_err(d_err[g])
    );
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", name, inst, $time, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 waiting for source, 2 on the bus, 3 completion pulse.
  int            ws    [NI] = '{0, 2, 3};
  int            m_ph  [NI];
  int            m_left[NI];
  int            m_sel [NI];
  logic          m_rw  [NI];
  logic          m_bw  [NI];
  logic          m_err [NI];
  logic [AW-1:0] m_addr[NI];

  function automatic logic [AW-1:0] src(input int i);
    return src_addr[i*AW +: AW];
  endfunction

  task automatic m_reset(input int k);
    m_ph[k] = 0; m_left[k] = 0; m_sel[k] = 0;
    m_rw[k] = 1'b0; m_bw[k] = 1'b0; m_err[k] = 1'b0;
    m_addr[k] = 16'hFFFE;
  endtask

  task automatic m_enter(input int k);
    logic [AW-1:0] raw;
    raw = src(m_sel[k]);
`ifdef MAB_ALIGN_CHECK_EN
    if (!m_bw[k] && raw[0]) begin
      m_err[k] = 1'b1;
      m_ph[k]  = 0;
      return;
    end
`endif
    m_addr[k] = m_bw[k] ? raw : (raw & 16'hFFFE);
    m_ph[k]   = 2;
    m_left[k] = ws[k];
  endtask

  task automatic m_step(input int k);
    m_err[k] = 1'b0;
    case (m_ph[k])
      0: if (start) begin
           m_sel[k] = (sel >= NS) ? 0 : int'(sel);
           m_rw[k]  = rw;
           m_bw[k]  = bw;
           if (src_valid[m_sel[k]]) m_enter(k);
           else begin m_ph[k] = 1; m_addr[k] = src(0); end
         end
      1: if (src_valid[m_sel[k]]) m_enter(k); else m_addr[k] = src(0);
      2: if (m_left[k] > 0) m_left[k]--; else if (mem_ready) m_ph[k] = 3;
      default: m_ph[k] = 0;
    endcase
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) m_reset(k);
      chk("mab_addr",  k, 32'(d_addr[k]), 32'(m_addr[k]));
      chk("mab_valid", k, 32'(d_valid[k]), 32'(m_ph[k] == 2));
      chk("busy",      k, 32'(d_busy[k]),  32'(m_ph[k] != 0));
      chk("mab_done",  k, 32'(d_done[k]),  32'(m_ph[k] == 3));
      chk("mab_rw",    k, 32'(d_rw[k]),    32'(m_rw[k]));
      chk("mab_bw",    k, 32'(d_bw[k]),    32'(m_bw[k]));
      chk("align_err", k, 32'(d_err[k]),   32'(m_err[k]));
      if (rst_n) m_step(k);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] a);
    src_addr[i*AW +: AW] = a;
  endtask

  task automatic wait_idle();
    int i;
    start = 1'b0; mem_ready = 1'b1; src_valid = '1;
    for (i = 0; i < 60 && (d_busy[0] || d_busy[1] || d_busy[2]); i++) tick();
    chk("idle_timeout", 0, 32'(d_busy[0] || d_busy[1] || d_busy[2]), 32'd0);
  endtask

  int v_cnt, d_cnt;

  initial begin
    rst_n = 1'b1; start = 1'b0; sel = '0; rw = 1'b0; bw = 1'b0;
    mem_ready = 1'b1; src_valid = '1; src_addr = '0;
    #1 rst_n = 1'b0;
    tick(); tick();
    chk("rst_addr",  0, 32'(d_addr[0]), 32'h0000FFFE);
    chk("rst_valid", 0, 32'(d_valid[0]), 32'd0);
    chk("rst_busy",  0, 32'(d_busy[0]), 32'd0);
    rst_n = 1'b1;
    tick();

    // sel=1 word access, zero wait states
    set_src(1, 16'h0200); sel = 3'd1; bw = 1'b0; rw = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    chk("lat_valid", 0, 32'(d_valid[0]), 32'd1);
    chk("lat_addr",  0, 32'(d_addr[0]), 32'h00000200);
    chk("lat_rw",    0, 32'(d_rw[0]), 32'd1);
    tick();
    chk("lat_done",  0, 32'(d_done[0]), 32'd1);
    wait_idle();

    // Source not yet valid: PC tracked on the bus address, then selected source
    set_src(0, 16'hC010); set_src(2, 16'h1234); src_valid = 5'b11011;
    sel = 3'd2; bw = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wsrc_addr",  0, 32'(d_addr[0]), 32'h0000C010);
      chk("wsrc_valid", 0, 32'(d_valid[0]), 32'd0);
      tick();
    end
    src_valid = 5'b11111;
    tick();
    chk("wsrc_acc_addr", 0, 32'(d_addr[0]), 32'h00001234);
    wait_idle();

    // Two wait states plus three cycles of mem_ready low
    set_src(3, 16'h0ABC); sel = 3'd3; bw = 1'b1; mem_ready = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    v_cnt = 0; d_cnt = 0;
    for (int i = 0; i < 20 && d_busy[1]; i++) begin
      if (d_valid[1]) begin
        v_cnt++;
        chk("stall_addr", 1, 32'(d_addr[1]), 32'h00000ABC);
      end
      if (d_done[1]) d_cnt++;
      mem_ready = (v_cnt >= 6);
      tick();
    end
    chk("stall_valid_cycles", 1, 32'(v_cnt), 32'd6);
    chk("stall_done_count",   1, 32'(d_cnt), 32'd1);
    wait_idle();

    // Out-of-range select falls back to PC
    set_src(0, 16'hF000); sel = 3'd7; bw = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    chk("sel7_addr", 0, 32'(d_addr[0]), 32'h0000F000);
    wait_idle();

    // Odd address, word access
    set_src(1, 16'h0201); sel = 3'd1; bw = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
`ifdef MAB_ALIGN_CHECK_EN
    chk("align_err",   0, 32'(d_err[0]), 32'd1);
    chk("align_valid", 0, 32'(d_valid[0]), 32'd0);
    tick();
    chk("align_done",  0, 32'(d_done[0]), 32'd0);
`else
    chk("odd_addr", 0, 32'(d_addr[0]), 32'h00000200);
`endif
    wait_idle();

    // Reset during ACCESS on the WAIT_STATES=3 instance
    set_src(0, 16'h4400); sel = 3'd0; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_addr",  2, 32'(d_addr[2]), 32'h0000FFFE);
    chk("arst_valid", 2, 32'(d_valid[2]), 32'd0);
    chk("arst_busy",  2, 32'(d_busy[2]), 32'd0);
    tick(); rst_n = 1'b1;
    d_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (d_done[2]) d_cnt++;
      tick();
    end
    chk("arst_no_done", 2, 32'(d_cnt), 32'd0);

    // Random traffic
    for (int c = 0; c < 2500; c++) begin
      start     = ($urandom_range(0, 3) == 0);
      sel       = SW'($urandom_range(0, 7));
      rw        = 1'($urandom);
      bw        = 1'($urandom);
      src_valid = 5'($urandom) | 5'b00001;
      for (int i = 0; i < NS; i++) set_src(i, 16'($urandom));
      mem_ready = ($urandom_range(0, 2) != 0);
      rst_n     = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst_n = 1'b1;
    wait_idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
